// File: rtl/conv_seq_pkg.sv
// Shared types for the conv layer sequencer: controller states and the
// field indices of the packed layer-parameter word.
package conv_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PARAMS = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int STRIDE = 0;
    localparam int OY0    = 1;
    localparam int FY     = 2;
    localparam int IC1    = 3;
    localparam int OC1    = 4;
    localparam int OY1    = 5;

endpackage

// File: rtl/mem_stream_reader.sv
// Turns a 1-cycle-latency SRAM read port into a valid/ready stream through a
// 2-entry skid buffer, reading addresses 0..len-1 in order.
module mem_stream_reader #(
    parameter int DATA_W     = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [CNT_WIDTH-1:0]  len,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [DATA_W-1:0]     dat,
    output logic                  vld,
    input  logic                  rdy,
    output logic                  complete
);

    logic [CNT_WIDTH-1:0] issued;
    logic [CNT_WIDTH-1:0] sent;
    logic [DATA_W-1:0]    entry [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic                 inflight;
    logic                 pop;
    logic [2:0]           occ;

    // Occupancy counts the beat leaving this cycle, so a new read can be
    // issued alongside a pop and the stream runs without bubbles.
    assign pop      = vld && rdy;
    assign occ      = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign mem_ren  = en && (issued < len) && (occ < 3'd2);
    assign mem_addr = issued[ADDR_WIDTH-1:0];
    assign vld      = (count != 2'd0);
    assign dat      = entry[rd_ptr];
    assign complete = (sent == len);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            issued   <= '0;
            sent     <= '0;
            entry[0] <= '0;
            entry[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= mem_ren;
            count    <= occ[1:0];
            if (mem_ren)
                issued <= issued + 1'b1;
            if (inflight) begin
                entry[wr_ptr] <= mem_rdata;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                sent   <= sent + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Layer controller for one conv_tiled: sends the parameter word once, streams
// ifmap/weights from SRAM and writes every returned ofmap word back to SRAM.
module conv_layer_sequencer
    import conv_seq_pkg::*;
#(
    parameter int PARAM_NUM  = 6,
    parameter int PARAM_WID  = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [PARAM_NUM*PARAM_WID-1:0] cfg_params,
    input  logic [CNT_WIDTH-1:0]           cfg_ifmap_len,
    input  logic [CNT_WIDTH-1:0]           cfg_weights_len,
    input  logic [CNT_WIDTH-1:0]           cfg_ofmap_len,
    output logic                           ifmap_mem_ren,
    output logic [ADDR_WIDTH-1:0]          ifmap_mem_addr,
    input  logic [15:0]                    ifmap_mem_rdata,
    output logic                           weights_mem_ren,
    output logic [ADDR_WIDTH-1:0]          weights_mem_addr,
    input  logic [15:0]                    weights_mem_rdata,
    output logic                           ofmap_mem_wen,
    output logic [ADDR_WIDTH-1:0]          ofmap_mem_addr,
    output logic [31:0]                    ofmap_mem_wdata,
    output logic [PARAM_NUM*PARAM_WID-1:0] layer_params_dat,
    output logic                           layer_params_vld,
    input  logic                           layer_params_rdy,
    output logic [15:0]                    ifmap_dat,
    output logic                           ifmap_vld,
    input  logic                           ifmap_rdy,
    output logic [15:0]                    weights_dat,
    output logic                           weights_vld,
    input  logic                           weights_rdy,
    input  logic [31:0]                    ofmap_dat,
    input  logic                           ofmap_vld,
    output logic                           ofmap_rdy,
    output logic                           busy,
    output logic                           done
);

    state_t                         state, state_nx;
    logic [PARAM_NUM*PARAM_WID-1:0] params_q;
    logic [CNT_WIDTH-1:0]           ifmap_len_q, weights_len_q, ofmap_len_q;
    logic [CNT_WIDTH-1:0]           ofmap_recv;
    logic                           take, run, of_hs;
    logic                           ifmap_cmp, weights_cmp, ofmap_cmp;

    assign take = (state == IDLE) && start;
    // Gated by rst so an abort issues no SRAM read in the reset cycle.
    assign run  = (state == STREAM) && !rst;

    mem_stream_reader #(.DATA_W(16), .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_ifmap_rd (
        .clk(clk), .rst(rst), .clr(take), .en(run), .len(ifmap_len_q),
        .mem_ren(ifmap_mem_ren), .mem_addr(ifmap_mem_addr), .mem_rdata(ifmap_mem_rdata),
        .dat(ifmap_dat), .vld(ifmap_vld), .rdy(ifmap_rdy), .complete(ifmap_cmp)
    );

    mem_stream_reader #(.DATA_W(16), .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_weights_rd (
        .clk(clk), .rst(rst), .clr(take), .en(run), .len(weights_len_q),
        .mem_ren(weights_mem_ren), .mem_addr(weights_mem_addr), .mem_rdata(weights_mem_rdata),
        .dat(weights_dat), .vld(weights_vld), .rdy(weights_rdy), .complete(weights_cmp)
    );

    assign ofmap_cmp        = (ofmap_recv == ofmap_len_q);
    assign ofmap_rdy        = run && !ofmap_cmp;
    assign of_hs            = ofmap_vld && ofmap_rdy;
    assign layer_params_dat = params_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            params_q        <= '0;
            ifmap_len_q     <= '0;
            weights_len_q   <= '0;
            ofmap_len_q     <= '0;
            ofmap_recv      <= '0;
            ofmap_mem_wen   <= 1'b0;
            ofmap_mem_addr  <= '0;
            ofmap_mem_wdata <= '0;
        end else begin
            state         <= state_nx;
            ofmap_mem_wen <= of_hs;
            if (take) begin
                params_q      <= cfg_params;
                ifmap_len_q   <= cfg_ifmap_len;
                weights_len_q <= cfg_weights_len;
                ofmap_len_q   <= cfg_ofmap_len;
                ofmap_recv    <= '0;
            end
            if (of_hs) begin
                ofmap_mem_addr  <= ofmap_recv[ADDR_WIDTH-1:0];
                ofmap_mem_wdata <= ofmap_dat;
                ofmap_recv      <= ofmap_recv + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx         = state;
        layer_params_vld = 1'b0;
        done             = 1'b0;
        busy             = (state != IDLE);
        case (state)
            IDLE:   if (start) state_nx = PARAMS;
            PARAMS: begin
                layer_params_vld = 1'b1;
                if (layer_params_rdy) state_nx = STREAM;
            end
            STREAM: if (ifmap_cmp && weights_cmp && ofmap_cmp) state_nx = DONE;
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer: stimulus queues expected beats,
// a negedge monitor pops and compares every DUT handshake and SRAM access.
module tb_conv_layer_sequencer;

    localparam logic [95:0] P_A = 96'h0001_0001_0001_0002_0003_0001;
    localparam logic [95:0] P_B = 96'h0002_0003_0004_0001_0005_0002;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [95:0] cfg_params = '0;
    logic [31:0] cfg_ifmap_len = '0, cfg_weights_len = '0, cfg_ofmap_len = '0;
    logic        ifmap_mem_ren, weights_mem_ren, ofmap_mem_wen;
    logic [15:0] ifmap_mem_addr, weights_mem_addr, ofmap_mem_addr;
    logic [15:0] ifmap_mem_rdata = '0, weights_mem_rdata = '0;
    logic [31:0] ofmap_mem_wdata;
    logic [95:0] layer_params_dat;
    logic        layer_params_vld, layer_params_rdy;
    logic [15:0] ifmap_dat, weights_dat;
    logic        ifmap_vld, ifmap_rdy, weights_vld, weights_rdy;
    logic [31:0] ofmap_dat;
    logic        ofmap_vld, ofmap_rdy, busy, done;

    always #5 clk = ~clk;

    conv_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .cfg_params(cfg_params),
        .cfg_ifmap_len(cfg_ifmap_len), .cfg_weights_len(cfg_weights_len), .cfg_ofmap_len(cfg_ofmap_len),
        .ifmap_mem_ren(ifmap_mem_ren), .ifmap_mem_addr(ifmap_mem_addr), .ifmap_mem_rdata(ifmap_mem_rdata),
        .weights_mem_ren(weights_mem_ren), .weights_mem_addr(weights_mem_addr), .weights_mem_rdata(weights_mem_rdata),
        .ofmap_mem_wen(ofmap_mem_wen), .ofmap_mem_addr(ofmap_mem_addr), .ofmap_mem_wdata(ofmap_mem_wdata),
        .layer_params_dat(layer_params_dat), .layer_params_vld(layer_params_vld), .layer_params_rdy(layer_params_rdy),
        .ifmap_dat(ifmap_dat), .ifmap_vld(ifmap_vld), .ifmap_rdy(ifmap_rdy),
        .weights_dat(weights_dat), .weights_vld(weights_vld), .weights_rdy(weights_rdy),
        .ofmap_dat(ofmap_dat), .ofmap_vld(ofmap_vld), .ofmap_rdy(ofmap_rdy),
        .busy(busy), .done(done)
    );

    int vec = 0, miss = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        vec++;
        miss++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // SRAM contents: ifmap word a = 0x1000+a, weights word a = 0x8000+a.
    always @(posedge clk) begin
        if (ifmap_mem_ren)   ifmap_mem_rdata   <= 16'h1000 + ifmap_mem_addr;
        if (weights_mem_ren) weights_mem_rdata <= 16'h8000 + weights_mem_addr;
    end

    // Accelerator model: ready sources and an ofmap producer (word i = 0xC0000000+i).
    bit   bp = 1'b0;
    logic irdy = 1'b1, wrdy = 1'b1, ogate = 1'b1, prdy = 1'b1;
    int   ohs = 0, obase = 0, onum = 0;
    assign ifmap_rdy        = irdy;
    assign weights_rdy      = wrdy;
    assign layer_params_rdy = prdy;
    assign ofmap_vld        = ((ohs - obase) < onum) && ogate;
    assign ofmap_dat        = 32'hC000_0000 + 32'(ohs - obase);

    logic [15:0] exp_if[$], exp_wt[$];
    logic [47:0] exp_wr[$];
    logic [95:0] exp_par[$];

    always @(posedge clk) begin
        #1;
        irdy  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        wrdy  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        ogate = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(posedge clk) begin
        if (!rst && ofmap_vld && ofmap_rdy) begin
            exp_wr.push_back({16'(ohs - obase), 32'hC000_0000 + 32'(ohs - obase)});
            ohs <= ohs + 1;
        end
    end

    // Monitor
    bit          par_ok = 1'b0, p_stall = 1'b0, if_stall = 1'b0, wt_stall = 1'b0;
    logic [95:0] p_prev = '0;
    logic [15:0] if_prev = '0, wt_prev = '0;
    int          if_addr = 0, wt_addr = 0, if_out = 0, wt_out = 0, if_beats = 0;
    int          ren_cnt = 0, wen_cnt = 0, done_cnt = 0, done_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            par_ok = 0; p_stall = 0; if_stall = 0; wt_stall = 0;
            if_addr = 0; wt_addr = 0; if_out = 0; wt_out = 0; if_beats = 0;
        end else begin
            if (start && !busy) begin
                par_ok = 0; if_addr = 0; wt_addr = 0; if_out = 0; wt_out = 0; if_beats = 0;
            end
            if (p_stall) begin
                chk("par_hold_vld", layer_params_vld, 1'b1);
                chk("par_hold_dat", layer_params_dat, p_prev);
            end
            if (layer_params_vld && layer_params_rdy) begin
                if (exp_par.size() == 0) flag("par_extra");
                else chk("par_word", layer_params_dat, exp_par.pop_front());
                par_ok = 1;
            end
            p_stall = layer_params_vld && !layer_params_rdy;
            p_prev  = layer_params_dat;

            if (if_stall) begin
                chk("if_hold_vld", ifmap_vld, 1'b1);
                chk("if_hold_dat", ifmap_dat, if_prev);
            end
            if (ifmap_vld && ifmap_rdy) begin
                if (exp_if.size() == 0) flag("if_extra");
                else chk("if_dat", ifmap_dat, exp_if.pop_front());
                if_beats++;
            end
            if (ifmap_mem_ren) begin
                chk("if_ren_after_par", par_ok, 1'b1);
                chk("if_addr", ifmap_mem_addr, 16'(if_addr));
                if_addr++;
                ren_cnt++;
            end
            if_out += int'(ifmap_mem_ren) - int'(ifmap_vld && ifmap_rdy);
            if (ifmap_mem_ren) chk("if_outstanding", (if_out <= 2), 1'b1);
            if_stall = ifmap_vld && !ifmap_rdy;
            if_prev  = ifmap_dat;

            if (wt_stall) begin
                chk("wt_hold_vld", weights_vld, 1'b1);
                chk("wt_hold_dat", weights_dat, wt_prev);
            end
            if (weights_vld && weights_rdy) begin
                if (exp_wt.size() == 0) flag("wt_extra");
                else chk("wt_dat", weights_dat, exp_wt.pop_front());
            end
            if (weights_mem_ren) begin
                chk("wt_ren_after_par", par_ok, 1'b1);
                chk("wt_addr", weights_mem_addr, 16'(wt_addr));
                wt_addr++;
                ren_cnt++;
            end
            wt_out += int'(weights_mem_ren) - int'(weights_vld && weights_rdy);
            if (weights_mem_ren) chk("wt_outstanding", (wt_out <= 2), 1'b1);
            wt_stall = weights_vld && !weights_rdy;
            wt_prev  = weights_dat;

            if (ofmap_mem_wen) begin
                wen_cnt++;
                if (exp_wr.size() == 0) flag("of_wr_extra");
                else chk("of_wr", {ofmap_mem_addr, ofmap_mem_wdata}, exp_wr.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check_idle_zero(input string tag);
        chk({tag, "_mem_ports"}, {ifmap_mem_ren, ifmap_mem_addr, weights_mem_ren, weights_mem_addr,
                                  ofmap_mem_wen, ofmap_mem_addr, ofmap_mem_wdata}, '0);
        chk({tag, "_params_dat"}, layer_params_dat, '0);
        chk({tag, "_streams"}, {layer_params_vld, ifmap_dat, ifmap_vld, weights_dat, weights_vld,
                                ofmap_rdy, busy, done}, '0);
    endtask

    // lat < 0 skips the start-to-done latency check; pstall > 0 holds
    // layer_params_rdy low until that many cycles after start.
    task automatic run_layer(input logic [95:0] p, input int li, input int lw, input int lo,
                             input int lat, input bit extra_start, input int pstall);
        int d0, s_cyc, t;
        for (int i = 0; i < li; i++) exp_if.push_back(16'h1000 + 16'(i));
        for (int i = 0; i < lw; i++) exp_wt.push_back(16'h8000 + 16'(i));
        exp_par.push_back(p);
        obase = ohs;
        onum  = lo;
        cfg_params = p; cfg_ifmap_len = li; cfg_weights_len = lw; cfg_ofmap_len = lo;
        prdy  = (pstall == 0);
        start = 1'b1;
        s_cyc = cyc;
        d0    = done_cnt;
        t     = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(posedge clk); #1;
            t++;
            start = extra_start && (t == 4 || t == 8);
            if (pstall > 0 && t == pstall) begin
                chk("par_vld_while_stalled", layer_params_vld, 1'b1);
                chk("par_dat_while_stalled", layer_params_dat, p);
            end
            if (t >= pstall) prdy = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", (done_cnt != d0), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        if (lat >= 0) chk("done_latency", done_cyc - s_cyc, lat);
        chk("if_left", exp_if.size(), 0);
        chk("wt_left", exp_wt.size(), 0);
        chk("wr_left", exp_wr.size(), 0);
        chk("par_left", exp_par.size(), 0);
        chk("busy_after", busy, 1'b0);
    endtask

    initial begin
        int r0, w0, t;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 3x3 layer, always ready: 32 ifmap beats + 5 cycles of pipeline
        w0 = wen_cnt;
        run_layer(P_A, 32, 16, 18, 37, 1'b0, 0);
        chk("a_wen_count", wen_cnt - w0, 18);

        // random backpressure on every stream
        bp = 1'b1;
        run_layer(P_B, 20, 24, 6, -1, 1'b0, 0);
        bp = 1'b0;
        @(posedge clk); #1;

        // parameter handshake stalled for 10 cycles
        run_layer(P_A, 5, 3, 2, -1, 1'b0, 11);

        // all lengths zero
        r0 = ren_cnt;
        w0 = wen_cnt;
        run_layer(P_B, 0, 0, 0, 3, 1'b0, 0);
        chk("zero_ren", ren_cnt - r0, 0);
        chk("zero_wen", wen_cnt - w0, 0);

        // abort mid-stream after 7 ifmap words
        for (int i = 0; i < 32; i++) exp_if.push_back(16'h1000 + 16'(i));
        for (int i = 0; i < 32; i++) exp_wt.push_back(16'h8000 + 16'(i));
        exp_par.push_back(P_A);
        obase = ohs; onum = 32;
        cfg_params = P_A; cfg_ifmap_len = 32; cfg_weights_len = 32; cfg_ofmap_len = 32;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (if_beats < 7 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("abort_reached_7", (if_beats >= 7), 1'b1);
        rst = 1'b1;
        onum = 0;
        @(posedge clk); #1;
        check_idle_zero("abort");
        exp_if.delete(); exp_wt.delete(); exp_wr.delete(); exp_par.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        run_layer(P_B, 4, 4, 2, 9, 1'b0, 0);

        // start pulses while busy are ignored
        run_layer(P_B, 8, 8, 4, 13, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
